// File: rtl/lif_post_neuron_if.sv
`default_nettype none
// ============================================================================
// Module      : lif_post_neuron_if
// Description : Bundles the time-step enable, presynaptic spike/weight inputs
//               and the neuron's status outputs.
//               master : drives en/pre_spike/weight, observes the outputs
//               slave  : the neuron itself
// Ports       : en, pre_spike[3:0], weight[15:0]          (master -> slave)
//               post_spike, membrane[V_WIDTH-1:0],
//               refractory, spike_count[7:0]              (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_post_neuron_if #(
    parameter int V_WIDTH = 8
);
    logic               en;
    logic [3:0]         pre_spike;
    logic [15:0]        weight;
    logic               post_spike;
    logic [V_WIDTH-1:0] membrane;
    logic               refractory;
    logic [7:0]         spike_count;

    modport master (
        output en, pre_spike, weight,
        input  post_spike, membrane, refractory, spike_count
    );

    modport slave (
        input  en, pre_spike, weight,
        output post_spike, membrane, refractory, spike_count
    );
endinterface
`default_nettype wire

// File: rtl/lif_post_neuron.sv
`default_nettype none
// ============================================================================
// Module      : lif_post_neuron
// Description : Leaky integrate-and-fire postsynaptic neuron. Sums the weights
//               of active presynaptic inputs, leaks v by v>>LEAK_SHIFT each
//               enabled cycle, saturates the membrane, fires a one-cycle
//               post_spike at THRESHOLD and then sits out REFRACT_CYCLES
//               enabled cycles.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               nif    - slave modport: en, pre_spike, weight in;
//                        post_spike, membrane, refractory, spike_count out
// Revision    : 1.0 - initial release
// ============================================================================
module lif_post_neuron #(
    parameter int NUM_PRE        = 4,
    parameter int V_WIDTH        = 8,
    parameter int THRESHOLD      = 40,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    lif_post_neuron_if.slave nif
);

    localparam logic [V_WIDTH-1:0] c_THRESHOLD = V_WIDTH'(THRESHOLD);
    localparam logic [3:0]         c_REFRACT   = 4'(REFRACT_CYCLES);
    localparam logic [V_WIDTH-1:0] c_V_MAX     = '1;

    typedef enum logic [0:0] {
        S_INTEG  = 1'b0,
        S_REFRAC = 1'b1
    } state_t;

    state_t             r_state;
    logic [3:0]         r_rcnt;
    logic [V_WIDTH-1:0] r_v;
    logic               r_post;
    logic [7:0]         r_count;

    logic [5:0]         w_sum;
    logic [V_WIDTH:0]   w_vn_wide;
    logic [V_WIDTH-1:0] w_vn;

    // Weight for neuron i sits in the i-th nibble counted from the MSB end.
    always_comb begin
        w_sum = 6'd0;
        for (int i = 0; i < NUM_PRE; i++) begin
            if (nif.pre_spike[i]) begin
                w_sum = w_sum + {2'b00, nif.weight[4*(NUM_PRE-1-i) +: 4]};
            end
        end
    end

    // v - (v>>LEAK_SHIFT) can never go negative, so only the upward
    // overflow from adding the sum needs the extra bit.
    always_comb begin
        w_vn_wide = {1'b0, r_v} - {1'b0, (r_v >> LEAK_SHIFT)}
                  + {{(V_WIDTH-5){1'b0}}, w_sum};
        w_vn      = w_vn_wide[V_WIDTH] ? c_V_MAX : w_vn_wide[V_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INTEG;
            r_rcnt  <= 4'd0;
            r_v     <= '0;
            r_post  <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_post <= 1'b0;
            if (nif.en) begin
                case (r_state)
                    S_INTEG: begin
                        if (w_vn >= c_THRESHOLD) begin
                            r_post <= 1'b1;
                            r_v    <= '0;
                            if (r_count != 8'hFF) begin
                                r_count <= r_count + 8'd1;
                            end
                            if (c_REFRACT != 4'd0) begin
                                r_state <= S_REFRAC;
                                r_rcnt  <= c_REFRACT;
                            end
                        end else begin
                            r_v <= w_vn;
                        end
                    end
                    S_REFRAC: begin
                        r_v <= '0;
                        if (r_rcnt == 4'd1) begin
                            r_state <= S_INTEG;
                            r_rcnt  <= 4'd0;
                        end else begin
                            r_rcnt <= r_rcnt - 4'd1;
                        end
                    end
                    default: begin
                        r_state <= S_INTEG;
                        r_rcnt  <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign nif.post_spike  = r_post;
    assign nif.membrane    = r_v;
    assign nif.refractory  = (r_state == S_REFRAC);
    assign nif.spike_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_lif_post_neuron.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_post_neuron
// Description : Directed-vector bench for lif_post_neuron. One instance with
//               default parameters, a second with THRESHOLD=255 for the
//               saturation case. Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_post_neuron;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    lif_post_neuron_if #(.V_WIDTH(8)) a_if ();
    lif_post_neuron_if #(.V_WIDTH(8)) b_if ();

    lif_post_neuron u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .nif   (a_if.slave)
    );

    lif_post_neuron #(.THRESHOLD(255)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .nif   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp5[11];
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_if.en = 1'b0; a_if.pre_spike = 4'h0; a_if.weight = 16'h0000;
        b_if.en = 1'b0; b_if.pre_spike = 4'h0; b_if.weight = 16'h0000;

        repeat (2) step();
        check("rst_post",  int'(a_if.post_spike),  0);
        check("rst_mem",   int'(a_if.membrane),    0);
        check("rst_refr",  int'(a_if.refractory),  0);
        check("rst_count", int'(a_if.spike_count), 0);
        rst_n = 1'b1;

        // Single input, weight 15: 15, 29, fire at 41.
        a_if.weight = 16'hF000; a_if.pre_spike = 4'b0001; a_if.en = 1'b1;
        step(); check("t2_e1_mem", int'(a_if.membrane), 15);
        step(); check("t2_e2_mem", int'(a_if.membrane), 29);
        check("t2_e2_post", int'(a_if.post_spike), 0);
        step();
        check("t2_e3_post",  int'(a_if.post_spike),  1);
        check("t2_e3_mem",   int'(a_if.membrane),    0);
        check("t2_e3_refr",  int'(a_if.refractory),  1);
        check("t2_e3_count", int'(a_if.spike_count), 1);
        for (int e = 4; e <= 6; e++) begin
            step();
            check($sformatf("t3_e%0d_refr", e), int'(a_if.refractory), 1);
            check($sformatf("t3_e%0d_post", e), int'(a_if.post_spike), 0);
            check($sformatf("t3_e%0d_mem", e),  int'(a_if.membrane),   0);
        end
        step(); check("t3_e7_refr", int'(a_if.refractory), 0);
        check("t3_e7_mem", int'(a_if.membrane), 0);
        step(); check("t3_e8_mem", int'(a_if.membrane), 15);
        step(); check("t3_e9_mem", int'(a_if.membrane), 29);
        step();
        check("t3_e10_post",  int'(a_if.post_spike),  1);
        check("t3_e10_count", int'(a_if.spike_count), 2);

        // Asynchronous reset between edges while refractory.
        step();
        check("t1_pre_refr", int'(a_if.refractory), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_refr",  int'(a_if.refractory),  0);
        check("t1_async_count", int'(a_if.spike_count), 0);
        check("t1_async_mem",   int'(a_if.membrane),    0);
        check("t1_async_post",  int'(a_if.post_spike),  0);
        #1;
        rst_n = 1'b1;

        // All inputs, full weights: sum 60 fires on the first edge.
        a_if.weight = 16'hFFFF; a_if.pre_spike = 4'hF;
        step();
        check("t4_post",  int'(a_if.post_spike),  1);
        check("t4_mem",   int'(a_if.membrane),    0);
        check("t4_count", int'(a_if.spike_count), 1);

        // All inputs, zero weights: never fires.
        do_reset();
        a_if.weight = 16'h0000;
        for (int e = 1; e <= 10; e++) begin
            step();
            check($sformatf("t4z_e%0d_post", e), int'(a_if.post_spike), 0);
        end
        check("t4z_mem",   int'(a_if.membrane),    0);
        check("t4z_count", int'(a_if.spike_count), 0);

        // Leak decay from 15 down to the floor at 7.
        do_reset();
        a_if.pre_spike = 4'b0010; a_if.weight = 16'h0F00;
        step(); check("t5_load", int'(a_if.membrane), 15);
        a_if.pre_spike = 4'b0000;
        exp5 = '{14, 13, 12, 11, 10, 9, 8, 7, 7, 7, 7};
        for (int k = 0; k < 11; k++) begin
            step();
            check($sformatf("t5_leak%0d", k), int'(a_if.membrane), exp5[k]);
        end
        check("t5_count", int'(a_if.spike_count), 0);
        a_if.en = 1'b0;

        // THRESHOLD=255 instance: saturation, and en=0 freezing.
        b_if.weight = 16'hFFFF; b_if.pre_spike = 4'hF; b_if.en = 1'b1;
        step(); check("t6_e1", int'(b_if.membrane), 60);
        step(); check("t6_e2", int'(b_if.membrane), 113);
        step(); check("t6_e3", int'(b_if.membrane), 159);
        b_if.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t6_frz%0d_mem", k),  int'(b_if.membrane),   159);
            check($sformatf("t6_frz%0d_post", k), int'(b_if.post_spike), 0);
        end
        b_if.en = 1'b1;
        step(); check("t6_e4", int'(b_if.membrane), 200);
        step(); check("t6_e5", int'(b_if.membrane), 235);
        step();
        check("t6_sat_post", int'(b_if.post_spike), 1);
        check("t6_sat_mem",  int'(b_if.membrane),   0);
        check("t6_sat_refr", int'(b_if.refractory), 1);
        step(); check("t6_r1_refr", int'(b_if.refractory), 1);
        b_if.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t6_rfrz%0d_refr", k), int'(b_if.refractory), 1);
            check($sformatf("t6_rfrz%0d_post", k), int'(b_if.post_spike), 0);
        end
        b_if.en = 1'b1;
        step(); check("t6_r2_refr", int'(b_if.refractory), 1);
        step(); check("t6_r3_refr", int'(b_if.refractory), 1);
        step(); check("t6_r4_refr", int'(b_if.refractory), 0);
        check("t6_r4_mem", int'(b_if.membrane), 0);
        step(); check("t6_reint", int'(b_if.membrane), 60);
        check("t6_count", int'(b_if.spike_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
